new_means_controller: RTL and testbench
=======================================

NEW_MEANS_CONTROLLER -- requirements
Module: new_means_controller

Interface
REQ-001 Parameter centroid_num, default 8: number of centroids sequenced per pass.
REQ-002 Parameter coord_num, default 7: coordinates per centroid (quotient lanes).
REQ-003 Parameter accum_cord_width, default 22: width of one quotient lane.
REQ-004 Parameter cordinate_width, default 13: width of one written centroid coordinate.
REQ-005 Parameter addrWidth, default 8: centroid memory address width.
REQ-006 Parameter cent_base, default 0: memory address of centroid 0.
REQ-007 Parameter div_timeout, default 64: maximum cycles waited for div_done.
REQ-008 Ports: one clock; reset is asynchronous and active-low.
REQ-009 clk  input  1  rising-edge clock.
REQ-010 rst_n  input  1  asynchronous active-low reset.
REQ-011 start  input  1  single-cycle request to run one means-update pass.
REQ-012 div_done  input  1  divider result valid for the current cent_cnt.
REQ-013 quotient  input  coord_num*accum_cord_width  per-lane quotients; lane 0 in the LSBs.
REQ-014 divide_by_0  input  1  current centroid count is zero; qualified by div_done.
REQ-015 divider_en  output  1  divider operand select and run enable.
REQ-016 cent_cnt  output  3  centroid index driven to the divider mux.
REQ-017 mem_wr_en  output  1  centroid memory write strobe.
REQ-018 mem_addr  output  addrWidth  write address, equal to cent_base+cent_cnt.
REQ-019 mem_wr_data  output  coord_num*cordinate_width  new centroid; lane 0 in the LSBs.
REQ-020 busy  output  1  high from the cycle after an accepted start until done.
REQ-021 done  output  1  single-cycle pulse at the end of a pass.
REQ-022 empty_cnt  output  4  count of centroids with divide_by_0 in the last pass.
REQ-023 timeout_err  output  1  sticky; set by a divider timeout, cleared by the next accepted start.

Function
REQ-024 FSM states: IDLE, DIV, WRITE, NEXT, DONE.
REQ-025 IDLE: start=1 -> DIV; cent_cnt=0, empty_cnt=0, timeout_err=0, busy=1.
REQ-026 start is ignored in any state other than IDLE.
REQ-027 DIV: divider_en=1 and the wait counter increments each cycle.
REQ-028 DIV with div_done=1: capture quotient and divide_by_0, then -> WRITE.
REQ-029 DIV with the wait counter reaching div_timeout and no div_done: timeout_err=1, -> DONE with no further writes.
REQ-030 WRITE lasts 1 cycle: mem_wr_en=1 with the registered data, unless divide_by_0 was captured.
REQ-031 WRITE with divide_by_0 captured: no write, so memory keeps the old centroid, and empty_cnt increments.
REQ-032 NEXT: if cent_cnt==centroid_num-1 -> DONE; otherwise cent_cnt increments and -> DIV with the wait counter cleared.
REQ-033 DONE: done=1 for 1 cycle, busy=0, -> IDLE; cent_cnt holds its last value.
REQ-034 divider_en=0 in every state except DIV.
REQ-035 Lane conversion: the low cordinate_width bits of each accum_cord_width quotient lane (see REQ-041/042).
REQ-036 Latency: a pass with divider latency L takes centroid_num*(L+2)+1 cycles from start to done, with done in the final cycle.
REQ-037 div_done outside DIV is ignored.

Reset
REQ-038 rst_n=0 forces, immediately and asynchronously: state IDLE, all outputs 0, capture registers 0, wait counter 0.
REQ-039 Reset mid-pass abandons the pass without a done pulse; the memory keeps any writes already issued.

Configuration
REQ-040 Macro NEW_MEANS_SATURATE_EN selects the lane conversion.
REQ-041 NEW_MEANS_SATURATE_EN defined: a lane with any nonzero bit above cordinate_width-1 outputs all ones (8191).
REQ-042 NEW_MEANS_SATURATE_EN undefined: plain truncation to the low cordinate_width bits.

Verification
REQ-043 start, divider L=3, all counts nonzero, lane0=100 per centroid -> 8 writes at addr 0..7 with lane0=100, done at cycle 41, empty_cnt=0.
REQ-044 divide_by_0=1 for centroids 2 and 5 -> no write at addr 2 or 5, empty_cnt=2, the other 6 writes occur.
REQ-045 div_done never asserted -> timeout_err=1 after 64 cycles in DIV, done pulses, 0 writes; the next start clears timeout_err.
REQ-046 lane0=9000 -> mem_wr_data lane0=8191 with NEW_MEANS_SATURATE_EN, 808 without.
REQ-047 rst_n low during DIV of centroid 4 -> outputs 0 and state IDLE immediately, no done; a new start restarts at cent_cnt=0.
REQ-048 start re-pulsed while busy and div_done asserted in IDLE -> no effect on sequence, cent_cnt or write count.

Source files
------------

// File: rtl/new_means_controller.sv
// -----------------------------------------------------------------------------
// new_means_controller
//
// Sequences one means-update pass over centroid_num centroids. For each
// centroid it enables the divider, waits for div_done (bounded by
// div_timeout cycles), captures the per-lane quotients and writes the
// converted centroid back to memory. A centroid whose count was zero
// (divide_by_0) is not written, so memory keeps its previous value, and it
// is tallied in empty_cnt.
//
// Configuration macro:
//   NEW_MEANS_SATURATE_EN  defined   : lanes that overflow cordinate_width
//                                      bits clamp to all ones
//                          undefined : lanes truncate to the low bits
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request one pass (accepted only when idle)
//   div_done     in   divider result valid for cent_cnt
//   quotient     in   coord_num lanes of accum_cord_width bits, lane 0 LSBs
//   divide_by_0  in   current centroid count is zero (qualified by div_done)
//   divider_en   out  divider operand select / run enable
//   cent_cnt     out  centroid index presented to the divider mux
//   mem_wr_en    out  centroid memory write strobe
//   mem_addr     out  write address, cent_base + cent_cnt
//   mem_wr_data  out  new centroid, coord_num lanes of cordinate_width bits
//   busy         out  pass in progress
//   done         out  one-cycle end-of-pass pulse
//   empty_cnt    out  centroids skipped for divide_by_0 in the last pass
//   timeout_err  out  sticky divider timeout flag, cleared by next start
// -----------------------------------------------------------------------------
module new_means_controller #(
  parameter int centroid_num     = 8,
  parameter int coord_num        = 7,
  parameter int accum_cord_width = 22,
  parameter int cordinate_width  = 13,
  parameter int addrWidth        = 8,
  parameter int cent_base        = 0,
  parameter int div_timeout      = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  div_done,
  input  logic [coord_num*accum_cord_width-1:0] quotient,
  input  logic                                  divide_by_0,
  output logic                                  divider_en,
  output logic [2:0]                            cent_cnt,
  output logic                                  mem_wr_en,
  output logic [addrWidth-1:0]                  mem_addr,
  output logic [coord_num*cordinate_width-1:0]  mem_wr_data,
  output logic                                  busy,
  output logic                                  done,
  output logic [3:0]                            empty_cnt,
  output logic                                  timeout_err
);

  localparam int WAIT_W = $clog2(div_timeout + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIV   = 3'd1,
    S_WRITE = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                                state, state_nxt;
  logic [WAIT_W-1:0]                     wait_cnt;
  logic [coord_num*accum_cord_width-1:0] quot_p1;
  logic                                  zero_p1;
  logic                                  last_cent;
  logic                                  wait_hit;

  assign last_cent = (cent_cnt == 3'(centroid_num - 1));
  // Hit on the div_timeout-th DIV cycle; a div_done in that same cycle wins.
  assign wait_hit  = (wait_cnt == WAIT_W'(div_timeout - 1));

  function automatic logic [cordinate_width-1:0] conv_lane(
    input logic [accum_cord_width-1:0] lane
  );
`ifdef NEW_MEANS_SATURATE_EN
    if (|lane[accum_cord_width-1:cordinate_width])
      return '1;
    return lane[cordinate_width-1:0];
`else
    return lane[cordinate_width-1:0];
`endif
  endfunction

`ifndef NEW_MEANS_SATURATE_EN
  // Truncation discards the upper lane bits by design.
  logic unused_quot_hi;
  assign unused_quot_hi = ^quot_p1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DIV;
      S_DIV: begin
        if (div_done)      state_nxt = S_WRITE;
        else if (wait_hit) state_nxt = S_DONE;
      end
      S_WRITE: state_nxt = S_NEXT;
      S_NEXT:  state_nxt = last_cent ? S_DONE : S_DIV;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counters, status flags and quotient capture (p1 = captured divider result)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cent_cnt    <= '0;
      empty_cnt   <= '0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
      quot_p1     <= '0;
      zero_p1     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cent_cnt    <= '0;
            empty_cnt   <= '0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
          end
        end
        S_DIV: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (div_done) begin
            quot_p1 <= quotient;
            zero_p1 <= divide_by_0;
          end else if (wait_hit) begin
            timeout_err <= 1'b1;
          end
        end
        S_WRITE: begin
          if (zero_p1) empty_cnt <= empty_cnt + 4'd1;
        end
        S_NEXT: begin
          if (!last_cent) begin
            cent_cnt <= cent_cnt + 3'd1;
            wait_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    divider_en = (state == S_DIV);
    mem_wr_en  = (state == S_WRITE) && !zero_p1;
    busy       = (state == S_DIV) || (state == S_WRITE) || (state == S_NEXT);
    done       = (state == S_DONE);
    mem_addr   = addrWidth'(cent_base) + addrWidth'(cent_cnt);
    mem_wr_data = '0;
    for (int l = 0; l < coord_num; l++)
      mem_wr_data[l*cordinate_width +: cordinate_width] =
        conv_lane(quot_p1[l*accum_cord_width +: accum_cord_width]);
  end

endmodule

// File: tb/tb_new_means_controller.sv
module tb_new_means_controller;

  localparam int N   = 8;
  localparam int CN  = 7;
  localparam int AW  = 22;
  localparam int CW  = 13;
  localparam int ADW = 8;
  localparam int TMO = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              div_done;
  logic [CN*AW-1:0]  quotient;
  logic              divide_by_0;
  logic              divider_en;
  logic [2:0]        cent_cnt;
  logic              mem_wr_en;
  logic [ADW-1:0]    mem_addr;
  logic [CN*CW-1:0]  mem_wr_data;
  logic              busy;
  logic              done;
  logic [3:0]        empty_cnt;
  logic              timeout_err;

  new_means_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .div_done    (div_done),
    .quotient    (quotient),
    .divide_by_0 (divide_by_0),
    .divider_en  (divider_en),
    .cent_cnt    (cent_cnt),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .done        (done),
    .empty_cnt   (empty_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-centroid divider results presented by the behavioural divider.
  logic [CN*AW-1:0] qv [N];
  bit               zv [N];

  // Results of the most recent pass, filled in by run_pass.
  int           last_done_c;
  int           nwrites;
  logic [CW-1:0] last_lane0;

  // Expected stored word: each lane reduced to CW bits by value arithmetic.
  function automatic logic [CN*CW-1:0] expect_word(input logic [CN*AW-1:0] q);
    logic [CN*CW-1:0] w;
    longint v;
    longint top;
    w = '0;
    top = (longint'(1) << CW);
    for (int l = 0; l < CN; l++) begin
      v = longint'(q[l*AW +: AW]);
`ifdef NEW_MEANS_SATURATE_EN
      if (v > top - 1) v = top - 1;
`endif
      w[l*CW +: CW] = CW'(v % top);
    end
    return w;
  endfunction

  function automatic logic [ADW+CN*CW+15:0] all_outs();
    return {divider_en, cent_cnt, mem_wr_en, mem_addr, mem_wr_data,
            busy, done, empty_cnt, timeout_err};
  endfunction

  task automatic randomize_centroids();
    int v;
    for (int i = 0; i < N; i++) begin
      for (int l = 0; l < CN; l++) begin
        if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 8191));
        else                           v = int'($urandom & 32'h003F_FFFF);
        qv[i][l*AW +: AW] = AW'(v);
      end
      zv[i] = 1'b0;
    end
  endtask

  // Runs one pass. The divider answers after lat DIV cycles (never, when
  // no_div is set). With noise set, start is re-pulsed while busy and
  // div_done / divide_by_0 toggle randomly outside DIV.
  task automatic run_pass(input int lat, input bit no_div, input bit noise,
                          input string tag);
    int                exp_addr [$];
    logic [CN*CW-1:0]  exp_data [$];
    int                nzero;
    int                exp_done;
    int                exp_den;
    int                den;
    int                dseen;
    bit                seen_done;
    nzero = 0;
    for (int i = 0; i < N; i++) begin
      if (zv[i]) nzero++;
      else if (!no_div) begin
        exp_addr.push_back(i);
        exp_data.push_back(expect_word(qv[i]));
      end
    end
    if (no_div) begin
      nzero    = 0;
      exp_done = 1 + TMO;
      exp_den  = TMO;
    end else begin
      exp_done = N * (lat + 2) + 1;
      exp_den  = N * lat;
    end
    nwrites = 0; den = 0; dseen = 0; seen_done = 0; last_done_c = -1;

    @(negedge clk);
    start       = 1'b1;
    div_done    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    divide_by_0 = 1'($urandom_range(0, 1));

    for (int c = 1; c <= exp_done + 20 && !seen_done; c++) begin
      @(negedge clk);
      start = (noise && busy) ? 1'($urandom_range(0, 1)) : 1'b0;

      checks++;
      if (busy !== (c < exp_done)) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b want %b", tag, c, busy, c < exp_done);
      end
      if (c == 1) begin
        checks++;
        if (cent_cnt !== 3'd0 || timeout_err !== 1'b0 || empty_cnt !== 4'd0) begin
          errors++;
          $display("FAIL %s start state: cent_cnt=%0d timeout_err=%b empty_cnt=%0d want 0/0/0",
                   tag, cent_cnt, timeout_err, empty_cnt);
        end
      end
      if (divider_en) den++;
      if (mem_wr_en) begin
        checks++;
        nwrites++;
        last_lane0 = mem_wr_data[CW-1:0];
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected write: addr=%0d data=%h", tag, mem_addr, mem_wr_data);
        end else begin
          int               ea;
          logic [CN*CW-1:0] ed;
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          if (mem_addr !== ADW'(ea) || mem_wr_data !== ed) begin
            errors++;
            $display("FAIL %s write: addr=%0d data=%h want addr=%0d data=%h",
                     tag, mem_addr, mem_wr_data, ea, ed);
          end
        end
      end
      if (done) begin
        seen_done   = 1'b1;
        last_done_c = c;
        checks++;
        if (c != exp_done) begin
          errors++;
          $display("FAIL %s done cycle: got %0d want %0d", tag, c, exp_done);
        end
        checks++;
        if (empty_cnt !== 4'(nzero) || timeout_err !== no_div) begin
          errors++;
          $display("FAIL %s end status: empty_cnt=%0d timeout_err=%b want %0d/%b",
                   tag, empty_cnt, timeout_err, nzero, no_div);
        end
        checks++;
        if (exp_addr.size() != 0 || den != exp_den) begin
          errors++;
          $display("FAIL %s pass totals: missing writes=%0d divider_en cycles=%0d want 0/%0d",
                   tag, exp_addr.size(), den, exp_den);
        end
      end

      // Behavioural divider and input noise for the next edge.
      if (divider_en) begin
        dseen++;
        div_done    = !no_div && (dseen == lat);
        quotient    = qv[cent_cnt];
        divide_by_0 = zv[cent_cnt];
      end else begin
        dseen       = 0;
        div_done    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        divide_by_0 = 1'($urandom_range(0, 1));
        quotient    = {5{$urandom}};
      end
    end
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL %s done never pulsed within %0d cycles: got none want cycle %0d",
               tag, exp_done + 20, exp_done);
    end
    start    = 1'b0;
    div_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; div_done = 1'b0; divide_by_0 = 1'b0; quotient = '0;
    #12;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %h want 0", all_outs());
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL post-reset idle outputs: got %h want 0", all_outs());
    end
  endtask

  task automatic test_basic();
    randomize_centroids();
    for (int i = 0; i < N; i++) qv[i][AW-1:0] = AW'(100);
    run_pass(3, 1'b0, 1'b0, "basic");
    checks++;
    if (last_done_c != 41 || nwrites != 8 || last_lane0 !== CW'(100)) begin
      errors++;
      $display("FAIL basic summary: done=%0d writes=%0d lane0=%0d want 41/8/100",
               last_done_c, nwrites, last_lane0);
    end
  endtask

  task automatic test_empty();
    randomize_centroids();
    zv[2] = 1'b1; zv[5] = 1'b1;
    run_pass(int'($urandom_range(1, 6)), 1'b0, 1'b0, "empty");
    checks++;
    if (nwrites != 6 || empty_cnt !== 4'd2) begin
      errors++;
      $display("FAIL empty summary: writes=%0d empty_cnt=%0d want 6/2", nwrites, empty_cnt);
    end
  endtask

  task automatic test_timeout();
    randomize_centroids();
    run_pass(1, 1'b1, 1'b0, "timeout");
    checks++;
    if (nwrites != 0) begin
      errors++;
      $display("FAIL timeout writes: got %0d want 0", nwrites);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout sticky: timeout_err=%b busy=%b want 1/0", timeout_err, busy);
    end
    // Next start must clear the flag (checked at the first pass cycle).
    randomize_centroids();
    run_pass(2, 1'b0, 1'b0, "timeout_clear");
  endtask

  task automatic test_lane_conversion();
    logic [CW-1:0] want;
`ifdef NEW_MEANS_SATURATE_EN
    want = CW'(8191);
`else
    want = CW'(808);
`endif
    randomize_centroids();
    for (int i = 0; i < N; i++) qv[i][AW-1:0] = AW'(9000);
    run_pass(2, 1'b0, 1'b0, "lane_conv");
    checks++;
    if (last_lane0 !== want) begin
      errors++;
      $display("FAIL lane_conv lane0: got %0d want %0d", last_lane0, want);
    end
  endtask

  task automatic test_reset_mid_pass();
    int  dseen;
    bit  hit;
    randomize_centroids();
    dseen = 0; hit = 1'b0;
    @(negedge clk); start = 1'b1;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (divider_en && cent_cnt == 3'd4) hit = 1'b1;
      else if (divider_en) begin
        dseen++;
        div_done = (dseen == 2); quotient = qv[cent_cnt]; divide_by_0 = 1'b0;
      end else begin
        dseen = 0; div_done = 1'b0;
      end
    end
    div_done = 1'b0;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midreset never reached centroid 4 DIV: got none want cent_cnt=4");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL midreset outputs: got %h want 0", all_outs());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset after release: done=%b busy=%b want 0/0", done, busy);
      end
    end
    randomize_centroids();
    run_pass(3, 1'b0, 1'b0, "restart");
  endtask

  task automatic test_noise();
    randomize_centroids();
    zv[$urandom_range(0, N-1)] = 1'b1;
    run_pass(int'($urandom_range(1, 5)), 1'b0, 1'b1, "noise");
  endtask

  task automatic test_random_passes();
    for (int p = 0; p < 4; p++) begin
      randomize_centroids();
      for (int i = 0; i < N; i++) zv[i] = ($urandom_range(0, 3) == 0);
      run_pass(int'($urandom_range(1, 10)), 1'b0, p[0], "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_timeout();
    test_lane_conversion();
    test_reset_mid_pass();
    test_noise();
    test_random_passes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
